io_spi_mgmt_sequencer: RTL and testbench
========================================

# io_spi_mgmt_sequencer

Parametrised management sequencer for the I/O module's SPI port: on command it enumerates the core board and up to NUM_INTF interface boards over the shared SPI master, decides the module's I/O mode from the core's ID byte, and reports the result on io_mode and the status LEDs. It drives the SPI master's divisor, go and transmit byte and its slave selects. It consumes the master's done strobe and receive byte. It adds retry, timeout, fault handling and interface presence detection.

## Interface
Parameters:
- NUM_INTF, 2: number of interface slave selects (1..8).
- DIV_WIDTH, 12: width of divisor and run_divisor.
- INIT_DIVISOR, 399: SPI divisor used during enumeration and after reset.
- PROBE_CMD, 8'h9F: command byte sent to every target.
- TIMEOUT_CYCLES, 1024: clk_in cycles allowed from tx_go to tx_done.
- RETRIES, 3: core probe attempts before FAULT.
- BLINK_BITS, 22: blink counter width; LED blink toggles on counter MSB.

Ports:
- clk_in  in  1  clock; all registers update on the falling edge.
- n_reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to (re)enumerate.
- run_divisor  in  DIV_WIDTH  divisor applied after successful enumeration.
- divisor  out  DIV_WIDTH  SPI master clock divisor.
- tx_go  out  1  one-cycle pulse starting one byte transfer.
- tx_done  in  1  one-cycle pulse, transfer complete, rx_buffer valid.
- tx_buffer  out  8  byte to transmit.
- rx_buffer  in  8  byte received.
- spi_n_ss_core  out  1  core slave select, active low.
- spi_n_ss_intf  out  NUM_INTF  interface slave selects, active low.
- io_mode  out  2  00 MGMT, 01 IN, 10 OUT, 11 FAULT.
- intf_present  out  NUM_INTF  bit i set when interface i answered.
- status_grn, status_red  out  1  status LEDs.

## Operation
- Reset values: state IDLE, divisor INIT_DIVISOR, tx_go 0, tx_buffer 8'h00, all slave selects 1, io_mode 00, intf_present 0, status_grn 0, status_red 1, retry and timeout counters 0.
- States: IDLE, SELECT, SEND_CMD, WAIT_CMD, SEND_DUMMY, WAIT_ID, DESELECT, EVAL, DONE, FAULT.
- Enumeration order is target 0 = core, then interfaces 0..NUM_INTF-1.
- IDLE: on start, go to SELECT, clear intf_present, set target 0, set retry count 0, force divisor to INIT_DIVISOR.
- SELECT: assert the target's select.
- SEND_CMD: pulse tx_go with tx_buffer = PROBE_CMD.
- WAIT_CMD: wait for tx_done.
- SEND_DUMMY: pulse tx_go with tx_buffer = 8'h00.
- WAIT_ID: on tx_done, capture rx_buffer as the ID.
- DESELECT: release all selects.
- EVAL for the core:
  - ID[7:6]=01 sets io_mode IN; ID[7:6]=10 sets io_mode OUT. Either then advances to interface 0.
  - Otherwise, or on timeout, increment the retry count and return to SELECT. Reaching RETRIES attempts goes to FAULT.
- EVAL for interface i:
  - ID other than 8'h00 or 8'hFF sets intf_present[i].
  - An absent interface or a timeout is not a fault: clear the bit and continue.
  - After the last interface, go to DONE and load divisor from run_divisor.
- Timeout: counter starts at each tx_go. If TIMEOUT_CYCLES elapse without tx_done, go to DESELECT and treat the byte as failed. tx_done on the expiry cycle counts as success.
- io_mode is 00 throughout enumeration. It takes its final value only on entry to DONE; a held intermediate value is not visible. FAULT sets io_mode 11.
- LEDs:
  - IDLE: red on, green off.
  - Enumerating: green blinks, red off.
  - DONE: green on, red off.
  - FAULT: red blinks, green off.
- start is ignored while enumerating. start in DONE or FAULT re-enumerates: io_mode returns to 00 and the LEDs switch to enumerating.
- tx_done outside WAIT_CMD or WAIT_ID is ignored.

## Timing
- tx_go is exactly one cycle wide. tx_buffer is valid on the tx_go cycle and held until the next tx_go.
- A select goes low one cycle before the first tx_go to that target. It stays low until the cycle after the ID tx_done.
- At least one cycle with all selects high separates consecutive targets. Never more than one select is low at a time.
- With an immediate-response master (tx_done 1 cycle after tx_go), one target takes 7 cycles from SELECT to EVAL inclusive. A full pass takes 7*(1+NUM_INTF)+1 cycles.
- divisor changes only in IDLE on start, and on DONE entry.
- Asynchronous reset mid-transfer releases all selects and drops tx_go immediately.

## Test plan
- Reset, then start; core ID 8'h80, interfaces return 8'h11 and 8'hFF -> io_mode 10, intf_present 2'b01, divisor equals run_divisor, green steady.
- Core ID 8'h40 -> io_mode 01. Confirm each target sees a PROBE_CMD byte then a 8'h00 byte, and exactly one select is low per transfer.
- Core returns 8'h00 three times -> three core attempts, then io_mode 11, red blinking, no interface select ever asserted.
- tx_done withheld on the second core byte -> timeout after 1024 cycles, retry issued. Next attempt returns 8'h80 -> io_mode 10.
- Assert n_reset low during WAIT_ID of interface 1 -> all selects 1 and tx_go 0 immediately. After reset, state IDLE, io_mode 00, red on.
- start in DONE -> io_mode drops to 00 the next cycle and re-enumerates. start pulses during enumeration have no effect.

Source files
------------

// File: rtl/io_spi_mgmt_sequencer.sv
// rtl/io_spi_mgmt_sequencer.sv - SPI management sequencer: probes core and interface boards and sets the I/O mode
// All state updates on the falling edge of clk_in; outputs are registered from the next state.
module io_spi_mgmt_sequencer #(
  parameter int         NUM_INTF       = 2,
  parameter int         DIV_WIDTH      = 12,
  parameter int         INIT_DIVISOR   = 399,
  parameter logic [7:0] PROBE_CMD      = 8'h9F,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         RETRIES        = 3,
  parameter int         BLINK_BITS     = 22
) (
  input  logic                 clk_in,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] run_divisor,
  output logic [DIV_WIDTH-1:0] divisor,
  output logic                 tx_go,
  input  logic                 tx_done,
  output logic [7:0]           tx_buffer,
  input  logic [7:0]           rx_buffer,
  output logic                 spi_n_ss_core,
  output logic [NUM_INTF-1:0]  spi_n_ss_intf,
  output logic [1:0]           io_mode,
  output logic [NUM_INTF-1:0]  intf_present,
  output logic                 status_grn,
  output logic                 status_red
);

  localparam int TGT_W = (NUM_INTF < 1) ? 1 : $clog2(NUM_INTF + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RT_W  = (RETRIES < 2) ? 1 : $clog2(RETRIES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_SEND_CMD, S_WAIT_CMD, S_SEND_DUMMY,
    S_WAIT_ID, S_DESELECT, S_EVAL, S_DONE, S_FAULT
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  divisor_q, divisor_d;
  logic                  tx_go_q, tx_go_d;
  logic [7:0]            tx_buf_q, tx_buf_d;
  logic                  n_ss_core_q, n_ss_core_d;
  logic [NUM_INTF-1:0]   n_ss_intf_q, n_ss_intf_d;
  logic [1:0]            io_mode_q, io_mode_d;
  logic [1:0]            mode_q, mode_d;
  logic [NUM_INTF-1:0]   present_q, present_d;
  logic [TGT_W-1:0]      target_q, target_d;
  logic [RT_W-1:0]       retry_q, retry_d;
  logic [TO_W-1:0]       timeout_q, timeout_d;
  logic [7:0]            id_q, id_d;
  logic                  failed_q, failed_d;
  logic [BLINK_BITS-1:0] blink_q;
  logic                  timed_out, sel_active;

  always_ff @(negedge clk_in or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      divisor_q   <= DIV_WIDTH'(INIT_DIVISOR);
      tx_go_q     <= 1'b0;
      tx_buf_q    <= 8'h00;
      n_ss_core_q <= 1'b1;
      n_ss_intf_q <= '1;
      io_mode_q   <= 2'b00;
      mode_q      <= 2'b00;
      present_q   <= '0;
      target_q    <= '0;
      retry_q     <= '0;
      timeout_q   <= '0;
      id_q        <= 8'h00;
      failed_q    <= 1'b0;
      blink_q     <= '0;
    end else begin
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      tx_go_q     <= tx_go_d;
      tx_buf_q    <= tx_buf_d;
      n_ss_core_q <= n_ss_core_d;
      n_ss_intf_q <= n_ss_intf_d;
      io_mode_q   <= io_mode_d;
      mode_q      <= mode_d;
      present_q   <= present_d;
      target_q    <= target_d;
      retry_q     <= retry_d;
      timeout_q   <= timeout_d;
      id_q        <= id_d;
      failed_q    <= failed_d;
      blink_q     <= blink_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    tx_buf_d  = tx_buf_q;
    io_mode_d = io_mode_q;
    mode_d    = mode_q;
    present_d = present_q;
    target_d  = target_q;
    retry_d   = retry_q;
    id_d      = id_q;
    failed_d  = failed_q;
    timed_out = (timeout_q >= TO_W'(TIMEOUT_CYCLES));

    case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          state_d   = S_SELECT;
          present_d = '0;
          target_d  = '0;
          retry_d   = '0;
          io_mode_d = 2'b00;
          divisor_d = DIV_WIDTH'(INIT_DIVISOR);
        end
      end
      S_SELECT:     state_d = S_SEND_CMD;
      S_SEND_CMD:   state_d = S_WAIT_CMD;
      S_WAIT_CMD: begin
        if (tx_done) begin
          state_d = S_SEND_DUMMY;
        end else if (timed_out) begin
          state_d  = S_DESELECT;
          failed_d = 1'b1;
        end
      end
      S_SEND_DUMMY: state_d = S_WAIT_ID;
      S_WAIT_ID: begin
        if (tx_done) begin
          id_d    = rx_buffer;
          state_d = S_DESELECT;
        end else if (timed_out) begin
          state_d  = S_DESELECT;
          failed_d = 1'b1;
        end
      end
      S_DESELECT:   state_d = S_EVAL;
      S_EVAL: begin
        if (target_q == '0) begin
          if (!failed_q && (id_q[7:6] == 2'b01 || id_q[7:6] == 2'b10)) begin
            mode_d   = id_q[7:6];
            target_d = TGT_W'(1);
            state_d  = S_SELECT;
          end else begin
            retry_d = retry_q + 1'b1;
            if (retry_d >= RT_W'(RETRIES)) begin
              state_d   = S_FAULT;
              io_mode_d = 2'b11;
            end else begin
              state_d = S_SELECT;
            end
          end
        end else begin
          // A silent or blank interface just reads as absent.
          for (int i = 0; i < NUM_INTF; i++) begin
            if (target_q == TGT_W'(i + 1)) begin
              present_d[i] = !failed_q && (id_q != 8'h00) && (id_q != 8'hFF);
            end
          end
          if (target_q == TGT_W'(NUM_INTF)) begin
            state_d   = S_DONE;
            io_mode_d = mode_q;
            divisor_d = run_divisor;
          end else begin
            target_d = target_q + 1'b1;
            state_d  = S_SELECT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_go_d = (state_d == S_SEND_CMD) || (state_d == S_SEND_DUMMY);
    if (state_d == S_SEND_CMD) begin
      tx_buf_d = PROBE_CMD;
      failed_d = 1'b0;
    end else if (state_d == S_SEND_DUMMY) begin
      tx_buf_d = 8'h00;
    end

    // timeout_q counts cycles elapsed since the most recent tx_go.
    if (tx_go_d) begin
      timeout_d = '0;
    end else if (state_q == S_SEND_CMD || state_q == S_SEND_DUMMY ||
                 state_q == S_WAIT_CMD || state_q == S_WAIT_ID) begin
      timeout_d = timeout_q + 1'b1;
    end else begin
      timeout_d = '0;
    end

    sel_active  = (state_d == S_SELECT) || (state_d == S_SEND_CMD) || (state_d == S_WAIT_CMD) ||
                  (state_d == S_SEND_DUMMY) || (state_d == S_WAIT_ID);
    n_ss_core_d = !(sel_active && target_d == '0);
    n_ss_intf_d = '1;
    for (int i = 0; i < NUM_INTF; i++) begin
      if (sel_active && target_d == TGT_W'(i + 1)) n_ss_intf_d[i] = 1'b0;
    end
  end

  always_comb begin
    status_grn = 1'b0;
    status_red = 1'b0;
    case (state_q)
      S_IDLE:  status_red = 1'b1;
      S_DONE:  status_grn = 1'b1;
      S_FAULT: status_red = blink_q[BLINK_BITS-1];
      default: status_grn = blink_q[BLINK_BITS-1];
    endcase
  end

  assign divisor       = divisor_q;
  assign tx_go         = tx_go_q;
  assign tx_buffer     = tx_buf_q;
  assign spi_n_ss_core = n_ss_core_q;
  assign spi_n_ss_intf = n_ss_intf_q;
  assign io_mode       = io_mode_q;
  assign intf_present  = present_q;

endmodule

// File: tb/tb_io_spi_mgmt_sequencer.sv
// tb/tb_io_spi_mgmt_sequencer.sv - scoreboard bench for io_spi_mgmt_sequencer with a behavioural SPI slave
// Inputs are driven and outputs sampled on the rising edge; the DUT updates on the falling edge.
module tb_io_spi_mgmt_sequencer;

  localparam int         N    = 2;
  localparam int         DW   = 12;
  localparam int         INIT = 399;
  localparam int         TO   = 1024;
  localparam int         RT   = 3;
  localparam int         BB   = 4;
  localparam logic [7:0] PCMD = 8'h9F;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] run_div = '0;
  logic [DW-1:0] divisor;
  logic          tx_go;
  logic          tx_done = 1'b0;
  logic [7:0]    tx_buffer;
  logic [7:0]    rx_buffer = 8'h00;
  logic          ss_core;
  logic [N-1:0]  ss_intf;
  logic [1:0]    io_mode;
  logic [N-1:0]  present;
  logic          grn, red;

  always #5 clk = ~clk;

  io_spi_mgmt_sequencer #(
    .NUM_INTF(N), .DIV_WIDTH(DW), .INIT_DIVISOR(INIT), .PROBE_CMD(PCMD),
    .TIMEOUT_CYCLES(TO), .RETRIES(RT), .BLINK_BITS(BB)
  ) dut (
    .clk_in(clk), .n_reset(n_reset), .start(start), .run_divisor(run_div),
    .divisor(divisor), .tx_go(tx_go), .tx_done(tx_done), .tx_buffer(tx_buffer),
    .rx_buffer(rx_buffer), .spi_n_ss_core(ss_core), .spi_n_ss_intf(ss_intf),
    .io_mode(io_mode), .intf_present(present), .status_grn(grn), .status_red(red)
  );

  typedef struct packed { logic [N:0] sel; logic [7:0] data; } xfer_t;
  typedef struct packed { logic [1:0] mode; logic [N-1:0] pres; logic [DW-1:0] div; } res_t;

  xfer_t      exp_xfer_q[$];
  res_t       exp_res_q[$];
  int         rsp_delay_q[$];
  logic [7:0] rsp_rx_q[$];

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scenario: per core attempt and per interface, the slave delay for the command
  // byte and the ID byte (0 = never answers) and the ID byte returned.
  int         c_d1[RT], c_d2[RT];
  logic [7:0] c_id[RT];
  int         i_d1[N], i_d2[N];
  logic [7:0] i_id[N];
  int         exp_lat;
  int         last_cnt;
  bit         push_result;

  function automatic bit tmo(input int d);
    return (d == 0) || (d > TO);
  endfunction

  task automatic set_defaults();
    for (int a = 0; a < RT; a++) begin c_d1[a] = 1; c_d2[a] = 1; c_id[a] = 8'h00; end
    for (int i = 0; i < N; i++) begin i_d1[i] = 1; i_d2[i] = 1; i_id[i] = 8'($urandom); end
    push_result = 1'b1;
  endtask

  task automatic push_xfer(input int tgt, input logic [7:0] data, input int d, input logic [7:0] rx);
    xfer_t x;
    x.sel = '1;
    x.sel[tgt] = 1'b0;
    x.data = data;
    exp_xfer_q.push_back(x);
    rsp_delay_q.push_back(d);
    rsp_rx_q.push_back(rx);
  endtask

  // Reference: a target costs SELECT, two SEND, two waits, DESELECT and EVAL;
  // a wait lasts the slave delay, or TIMEOUT cycles if it never answers in time.
  task automatic plan();
    int         lat;
    bit         ok;
    logic [1:0] mode;
    logic [N-1:0] pres;
    res_t       res;
    lat = 1; ok = 1'b0; mode = 2'b00; pres = '0;
    for (int a = 0; a < RT && !ok; a++) begin
      push_xfer(0, PCMD, c_d1[a], 8'($urandom));
      if (tmo(c_d1[a])) lat += 4 + TO;
      else begin
        push_xfer(0, 8'h00, c_d2[a], c_id[a]);
        if (tmo(c_d2[a])) lat += 5 + c_d1[a] + TO;
        else begin
          lat += 5 + c_d1[a] + c_d2[a];
          if (c_id[a][7:6] == 2'b01 || c_id[a][7:6] == 2'b10) begin ok = 1'b1; mode = c_id[a][7:6]; end
        end
      end
    end
    if (ok) begin
      for (int i = 0; i < N; i++) begin
        push_xfer(i + 1, PCMD, i_d1[i], 8'($urandom));
        if (tmo(i_d1[i])) lat += 4 + TO;
        else begin
          push_xfer(i + 1, 8'h00, i_d2[i], i_id[i]);
          if (tmo(i_d2[i])) lat += 5 + i_d1[i] + TO;
          else begin
            lat += 5 + i_d1[i] + i_d2[i];
            pres[i] = (i_id[i] != 8'h00) && (i_id[i] != 8'hFF);
          end
        end
      end
      res.mode = mode; res.pres = pres; res.div = run_div;
    end else begin
      res.mode = 2'b11; res.pres = '0; res.div = DW'(INIT);
    end
    exp_lat = lat;
    if (push_result) exp_res_q.push_back(res);
  endtask

  // SPI slave: answers each tx_go after the scripted delay with the scripted byte.
  int         pend = 0;
  logic [7:0] pbyte = 8'h00;
  always @(posedge clk) begin
    if (!n_reset) begin
      tx_done = 1'b0;
      pend = 0;
    end else begin
      tx_done = 1'b0;
      rx_buffer = 8'($urandom);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin tx_done = 1'b1; rx_buffer = pbyte; end
      end
      if (tx_go && rsp_delay_q.size() > 0) begin
        pend = rsp_delay_q.pop_front();
        pbyte = rsp_rx_q.pop_front();
      end
    end
  end

  // Transfer monitor: every tx_go must match the next expected (select, byte) pair.
  always @(posedge clk) begin
    int    nl;
    xfer_t x;
    if (n_reset) begin
      nl = 0;
      if (!ss_core) nl++;
      for (int i = 0; i < N; i++) if (!ss_intf[i]) nl++;
      check("at_most_one_select", 32'(nl <= 1), 32'd1);
      if (tx_go) begin
        check("xfer_expected", 32'(exp_xfer_q.size() != 0), 32'd1);
        if (exp_xfer_q.size() != 0) begin
          x = exp_xfer_q.pop_front();
          check("xfer_selects", 32'({ss_intf, ss_core}), 32'(x.sel));
          check("xfer_byte", 32'(tx_buffer), 32'(x.data));
          check("enum_divisor", 32'(divisor), 32'(INIT));
        end
      end
    end
  end

  // Result monitor: io_mode leaving 00 marks DONE or FAULT entry.
  logic [1:0] prev_mode = 2'b00;
  always @(posedge clk) begin
    res_t r;
    if (n_reset && io_mode != 2'b00 && prev_mode == 2'b00) begin
      check("result_expected", 32'(exp_res_q.size() != 0), 32'd1);
      if (exp_res_q.size() != 0) begin
        r = exp_res_q.pop_front();
        check("io_mode", 32'(io_mode), 32'(r.mode));
        check("intf_present", 32'(present), 32'(r.pres));
        check("final_divisor", 32'(divisor), 32'(r.div));
      end
    end
    prev_mode = io_mode;
  end

  task automatic run_enum(input bit extra_starts);
    int cnt;
    bit seen_zero, done;
    plan();
    @(posedge clk);
    start = 1'b1;
    cnt = 0; seen_zero = 1'b0; done = 1'b0;
    while (!done && cnt < 20000) begin
      @(posedge clk);
      cnt++;
      start = extra_starts && (cnt == 4 || cnt == 11);
      if (cnt == 1) begin
        check("mode_cleared_on_start", 32'(io_mode), 32'd0);
        check("red_off_enumerating", 32'(red), 32'd0);
      end
      if (io_mode == 2'b00) seen_zero = 1'b1;
      else if (seen_zero) done = 1'b1;
    end
    start = 1'b0;
    last_cnt = cnt;
    check("enum_completed", 32'(done), 32'd1);
    check("enum_latency", 32'(cnt), 32'(exp_lat));
    check("xfers_consumed", 32'(exp_xfer_q.size()), 32'd0);
  endtask

  task automatic check_done_leds();
    check("done_grn", 32'(grn), 32'd1);
    check("done_red", 32'(red), 32'd0);
  endtask

  task automatic blink_check(input string name, input bit want_red);
    bit s0, s1, other;
    s0 = 1'b0; s1 = 1'b0; other = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if ((want_red ? red : grn) == 1'b1) s1 = 1'b1; else s0 = 1'b0 | 1'b1;
      other |= (want_red ? grn : red);
    end
    check({name, "_blinks"}, 32'(s0 && s1), 32'd1);
    check({name, "_other_led_off"}, 32'(other), 32'd0);
  endtask

  initial begin
    int w;
    repeat (2) @(posedge clk);
    check("rst_divisor", 32'(divisor), 32'(INIT));
    check("rst_tx_go", 32'(tx_go), 32'd0);
    check("rst_tx_buffer", 32'(tx_buffer), 32'd0);
    check("rst_selects", 32'({ss_intf, ss_core}), 32'({(N+1){1'b1}}));
    check("rst_io_mode", 32'(io_mode), 32'd0);
    check("rst_present", 32'(present), 32'd0);
    check("rst_leds", 32'({grn, red}), 32'b01);
    n_reset = 1'b1;
    repeat (3) @(posedge clk);

    set_defaults();
    c_id[0] = 8'h80; i_id[0] = 8'h11; i_id[1] = 8'hFF;
    run_div = 12'd57;
    run_enum(1'b0);
    check("full_pass_cycles", 32'(last_cnt), 32'(7 * (1 + N) + 1));
    check_done_leds();
    repeat (3) @(posedge clk);

    set_defaults();
    c_id[0] = 8'h40;
    run_div = DW'($urandom);
    run_enum(1'b1);
    check_done_leds();

    set_defaults();
    run_enum(1'b0);
    blink_check("fault_red", 1'b1);

    set_defaults();
    c_d2[0] = TO + 1; c_id[0] = 8'h80; c_id[1] = 8'h80;
    run_div = DW'($urandom);
    run_enum(1'b0);
    check_done_leds();

    set_defaults();
    c_d2[0] = TO; c_id[0] = 8'h40; i_d1[0] = 0;
    run_div = DW'($urandom);
    run_enum(1'b0);

    for (int s = 0; s < 6; s++) begin
      set_defaults();
      for (int a = 0; a < RT; a++) begin
        c_d1[a] = $urandom_range(1, 3);
        c_d2[a] = $urandom_range(1, 3);
        c_id[a] = 8'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        i_d1[i] = $urandom_range(1, 3);
        i_d2[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
        case ($urandom_range(0, 3))
          0: i_id[i] = 8'h00;
          1: i_id[i] = 8'hFF;
          default: i_id[i] = 8'($urandom);
        endcase
      end
      run_div = DW'($urandom);
      run_enum(1'($urandom));
    end

    set_defaults();
    c_id[0] = 8'h80; i_id[0] = 8'h33; i_d2[1] = 0;
    push_result = 1'b0;
    plan();
    @(posedge clk);
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    w = 0;
    while (exp_xfer_q.size() != 0 && w < 2000) begin @(posedge clk); w++; end
    check("reached_intf1_wait_id", 32'(exp_xfer_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    blink_check("enum_grn", 1'b0);
    #3 n_reset = 1'b0;
    #1;
    check("async_rst_selects", 32'({ss_intf, ss_core}), 32'({(N+1){1'b1}}));
    check("async_rst_tx_go", 32'(tx_go), 32'd0);
    check("async_rst_io_mode", 32'(io_mode), 32'd0);
    exp_xfer_q.delete();
    rsp_delay_q.delete();
    rsp_rx_q.delete();
    repeat (3) @(posedge clk);
    n_reset = 1'b1;
    repeat (4) @(posedge clk);
    check("post_rst_leds", 32'({grn, red}), 32'b01);
    check("post_rst_io_mode", 32'(io_mode), 32'd0);
    check("post_rst_divisor", 32'(divisor), 32'(INIT));
    check("post_rst_present", 32'(present), 32'd0);

    set_defaults();
    c_id[0] = 8'h80;
    run_div = DW'($urandom);
    run_enum(1'b0);
    check_done_leds();

    repeat (5) @(posedge clk);
    check("results_consumed", 32'(exp_res_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
